// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding, widths and duty helpers for the servo PWM stage.
package pwm_pkg;

    localparam int DUTY_W       = 8;
    localparam int PERIOD_TICKS = 256;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/control_pwm_servo_if.sv
// control_pwm_servo_if: duty-word handshake from the filter/truncation path.
// valid/ready: the source holds dato_valid and dato_duty stable until a cycle with
// dato_valid && dato_ready, which transfers exactly one word; ready never depends on valid.
interface control_pwm_servo_if;
    import pwm_pkg::*;

    logic  dato_valid;
    duty_t dato_duty;
    logic  dato_ready;

    modport master (output dato_valid, output dato_duty, input dato_ready);
    modport slave  (input dato_valid, input dato_duty, output dato_ready);

endinterface

// File: rtl/control_pwm_servo_divisor_tick.sv
// divisor_tick: clock-enable generator, one tick every PRESCALE clocks.
// clear_i holds the count at 0 and suppresses the tick.
module divisor_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int             CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_pwm_servo.sv
// control_pwm_servo: shadow-buffered duty sequencer, sample pacer and PWM generator.
// Define DUTY_LIMIT_EN to clamp the applied duty to [DUTY_MIN, DUTY_MAX].
module control_pwm_servo
    import pwm_pkg::*;
#(
    parameter int    PRESCALE   = 4,
    parameter int    SAMPLE_DIV = 16,
    parameter duty_t DUTY_MIN   = 8'd10,
    parameter duty_t DUTY_MAX   = 8'd245
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    control_pwm_servo_if.slave dato,
    output logic               muestra_req,
    output logic               pwm_out,
    output logic               fin_periodo,
    output duty_t              duty_activo,
    output logic               falta_dato,
    output state_e             state_dbg
);

    localparam int          DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam duty_t       CNT_LAST = DUTY_W'(PERIOD_TICKS - 1);

    state_e            state_q, state_d;
    duty_t             cnt_q, cnt_d;
    duty_t             duty_q, duty_d;
    duty_t             shadow_q, shadow_d;
    logic              full_q, full_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pwm_q, pwm_d;
    logic              fin_q, fin_d;
    logic              req_q, req_d;
    logic              falta_q, falta_d;
    logic              got_q, got_d;
    logic              req_seen_q, req_seen_d;

    logic              tick;
    logic              running;
    logic              presc_clear;
    logic              entry;
    logic              boundary;
    logic              accept;
    logic              load;
    logic              sample_due;
    duty_t             limited;

    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor_tick (
        .clk     (clk),
        .reset   (reset),
        .clear_i (presc_clear),
        .tick_o  (tick)
    );

    assign boundary = running && tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN returns to RUN as soon as enable comes back, without touching the counters.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running     = 1'b0;
        presc_clear = 1'b1;
        entry       = 1'b0;
        unique case (state_q)
            IDLE:       entry = enable;
            RUN, DRAIN: begin
                running     = 1'b1;
                presc_clear = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef DUTY_LIMIT_EN
    assign limited = clamp_duty(shadow_q, DUTY_MIN, DUTY_MAX);
`else
    logic unused_duty_limits;
    assign unused_duty_limits = ^{DUTY_MIN, DUTY_MAX};
    assign limited = shadow_q;
`endif

    // Run entry behaves as a boundary: it applies the shadow and starts a sample interval.
    assign accept     = dato.dato_valid && !full_q;
    assign load       = (entry || boundary) && full_q;
    assign sample_due = entry || (boundary && (div_q == DIV_LAST));

    always_comb begin
        cnt_d = cnt_q;
        if (!running) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + DUTY_W'(1);
        end

        div_d = div_q;
        if (entry) begin
            div_d = '0;
        end else if (boundary) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        full_d   = full_q;
        shadow_d = shadow_q;
        duty_d   = duty_q;
        if (load) begin
            full_d = 1'b0;
            duty_d = limited;
        end else if (accept) begin
            full_d   = 1'b1;
            shadow_d = dato.dato_duty;
        end

        pwm_d = running && (cnt_q < duty_q);
        fin_d = boundary;
        req_d = sample_due;

        got_d      = got_q;
        req_seen_d = req_seen_q || sample_due;
        falta_d    = falta_q;
        if (sample_due) begin
            got_d = 1'b0;
            if (req_seen_q && !(got_q || accept)) falta_d = 1'b1;
        end else if (accept) begin
            got_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= '0;
            full_q     <= 1'b0;
            shadow_q   <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            fin_q      <= 1'b0;
            req_q      <= 1'b0;
            got_q      <= 1'b0;
            req_seen_q <= 1'b0;
            falta_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            full_q     <= full_d;
            shadow_q   <= shadow_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            fin_q      <= fin_d;
            req_q      <= req_d;
            got_q      <= got_d;
            req_seen_q <= req_seen_d;
            falta_q    <= falta_d;
        end
    end

    assign dato.dato_ready = !full_q;
    assign muestra_req     = req_q;
    assign pwm_out         = pwm_q;
    assign fin_periodo     = fin_q;
    assign duty_activo     = duty_q;
    assign falta_dato      = falta_q;
    assign state_dbg       = state_q;

endmodule
